// File: rtl/ob_scan_console.sv
// Host side of the CPU observer port: debounced buttons pick mode/register, the sampled
// word is captured after a settle blackout and scanned out as 8 hex digits on a 7-seg display.
module ob_scan_console #(
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 5,
  parameter int DIGITS      = 8,
  parameter int DEB_CYC     = 100000,
  parameter int REFRESH_DIV = 50000,
  parameter int SETTLE_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode_i,
  input  logic              btn_next_i,
  input  logic              btn_prev_i,
  output logic [SEL_W-1:0]  ob_sel_o,
  output logic [2:0]        ob_mode_o,
  input  logic [DATA_W-1:0] ob_data_i,
  output logic [7:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int DCW = $clog2(DEB_CYC + 1);
  localparam int RCW = $clog2(REFRESH_DIV + 1);
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int IW  = $clog2(DIGITS);
  localparam logic [DCW-1:0] DEB_MAX = DCW'(DEB_CYC - 1);
  localparam logic [RCW-1:0] REF_MAX = RCW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]  IDX_MAX = IW'(DIGITS - 1);

  // button index: 0 mode, 1 next, 2 prev
  logic [2:0]     btn_raw, sync1, sync2, acc, pulse;
  logic [DCW-1:0] deb_cnt [3];

  logic [SEL_W-1:0]  sel_nx;
  logic [2:0]        mode_nx;
  logic [SCW-1:0]    settle_cnt;
  logic [DATA_W-1:0] shadow;
  logic [RCW-1:0]    ref_cnt;
  logic [IW-1:0]     idx;
  logic [3:0]        nib;

  assign btn_raw = {btn_prev_i, btn_next_i, btn_mode_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          acc[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pulse fires in the cycle whose edge flips the accepted level 0->1.
  always_comb begin
    pulse = '0;
    for (int i = 0; i < 3; i++)
      pulse[i] = sync2[i] & ~acc[i] & (deb_cnt[i] == DEB_MAX);
  end

  // Mode: 0 GPR, 1 PC, 2 IR, 3 ALU A, 4 ALU B, 5 ALU out. Mode pulse has priority.
  always_comb begin
    sel_nx  = ob_sel_o;
    mode_nx = ob_mode_o;
    if (pulse[0]) begin
      mode_nx = (ob_mode_o == 3'd5) ? 3'd0 : ob_mode_o + 3'd1;
    end else if (ob_mode_o == 3'd0 && (pulse[1] ^ pulse[2])) begin
      sel_nx = pulse[1] ? ob_sel_o + SEL_W'(1) : ob_sel_o - SEL_W'(1);
    end
  end

  // Observer output is registered, so hold off capture until it reflects the new sel/mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_sel_o   <= '0;
      ob_mode_o  <= '0;
      settle_cnt <= SCW'(SETTLE_CYC);
      shadow     <= '0;
    end else begin
      ob_sel_o  <= sel_nx;
      ob_mode_o <= mode_nx;
      if (sel_nx != ob_sel_o || mode_nx != ob_mode_o)
        settle_cnt <= SCW'(SETTLE_CYC);
      else if (settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;
      if (settle_cnt == '0)
        shadow <= ob_data_i;
    end
  end

  assign nib = shadow[idx*4 +: 4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
      idx     <= '0;
      an_o    <= '1;
      seg_o   <= 8'hFF;
    end else begin
      if (ref_cnt == REF_MAX) begin
        ref_cnt <= '0;
        idx     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      an_o  <= ~(DIGITS'(1) << idx);
      seg_o <= {1'b1, hex7(nib)};
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

endmodule

// File: tb/tb_ob_scan_console.sv
// Directed bench for ob_scan_console with short debounce/refresh/settle parameters.
module tb_ob_scan_console;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_next, btn_prev;
  logic [4:0]  ob_sel;
  logic [2:0]  ob_mode;
  logic [31:0] ob_data;
  logic [7:0]  seg;
  logic [7:0]  an;

  int checks = 0;
  int failures = 0;

  ob_scan_console #(
    .DATA_W(32), .SEL_W(5), .DIGITS(8),
    .DEB_CYC(4), .REFRESH_DIV(3), .SETTLE_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_mode_i(btn_mode), .btn_next_i(btn_next), .btn_prev_i(btn_prev),
    .ob_sel_o(ob_sel), .ob_mode_o(ob_mode), .ob_data_i(ob_data),
    .seg_o(seg), .an_o(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_mode = v;
      1: btn_next = v;
      default: btn_prev = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    step(10);
    set_btn(b, 1'b0);
    step(12);
  endtask

  // waits for an_o to newly become target, bounded
  task automatic wait_an(input logic [7:0] target, output bit ok);
    logic [7:0] p;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      p = an;
      step(1);
      if (an == target && p != target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit ok;

  initial begin
    rst = 1'b0;
    btn_mode = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    ob_data = 32'h0;
    step(3);
    check("rst_sel", ob_sel, 0);
    check("rst_mode", ob_mode, 0);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    rst = 1'b1;
    step(1);
    check("first_an", an, 8'hFE);
    step(10);

    // mode change latency: 2 sync + 4 debounce cycles
    btn_mode = 1'b1;
    step(5);
    check("mode_lat5", ob_mode, 0);
    step(1);
    check("mode_lat6", ob_mode, 1);
    step(4);
    btn_mode = 1'b0;
    step(12);
    for (int m = 2; m <= 6; m++) begin
      press(0);
      check("mode_cycle", ob_mode, m % 6);
    end

    // bounce shorter than debounce window is ignored
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1; step(3);
      btn_next = 1'b0; step(3);
    end
    step(10);
    check("bounce_sel", ob_sel, 0);
    press(1);
    check("next_sel", ob_sel, 1);
    press(2);
    check("prev_sel", ob_sel, 0);
    press(2);
    check("prev_wrap", ob_sel, 31);

    press(0); press(0);
    check("mode2", ob_mode, 2);
    press(1);
    check("next_ignored", ob_sel, 31);
    press(0); press(0); press(0); press(0);
    check("mode_back0", ob_mode, 0);

    // mode + next together: mode wins
    btn_mode = 1'b1; btn_next = 1'b1;
    step(10);
    btn_mode = 1'b0; btn_next = 1'b0;
    step(12);
    check("simul_mode", ob_mode, 1);
    check("simul_sel", ob_sel, 31);
    for (int i = 0; i < 5; i++) press(0);
    check("mode_back0b", ob_mode, 0);
    btn_next = 1'b1; btn_prev = 1'b1;
    step(10);
    btn_next = 1'b0; btn_prev = 1'b0;
    step(12);
    check("next_prev_sel", ob_sel, 31);

    // settle blackout: sel changes on 6th edge, new data appears right after
    btn_next = 1'b1;
    step(6);
    check("settle_sel", ob_sel, 0);
    ob_data = 32'h1234ABCD;
    check("shadow_e0", dut.shadow, 32'h0);
    step(1);
    check("shadow_e1", dut.shadow, 32'h0);
    step(1);
    check("shadow_e2", dut.shadow, 32'h0);
    step(1);
    check("shadow_e3", dut.shadow, 32'h1234ABCD);
    step(1);
    btn_next = 1'b0;
    step(12);

    // display scan
    wait_an(8'hFE, ok);
    check("wait_d0", ok, 1);
    check("d0_seg", seg, 8'hA1);
    step(2);
    check("d0_hold", an, 8'hFE);
    step(1);
    check("d1_an", an, 8'hFD);
    check("d1_seg", seg, 8'hC6);
    wait_an(8'hFB, ok);
    check("wait_d2", ok, 1);
    check("d2_seg", seg, 8'h83);
    wait_an(8'h7F, ok);
    check("wait_d7", ok, 1);
    check("d7_seg", seg, 8'hF9);

    // async reset mid-scan
    for (int i = 0; i < 5; i++) press(1);
    check("sel5", ob_sel, 5);
    for (int i = 0; i < 3; i++) press(0);
    check("mode3", ob_mode, 3);
    wait_an(8'hEF, ok);
    check("wait_d4", ok, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_sel", ob_sel, 0);
    check("arst_mode", ob_mode, 0);
    check("arst_an", an, 8'hFF);
    check("arst_seg", seg, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
